// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - accumulator-style execution unit with A/B registers, carry, pc and blocking IN/OUT ports
// Instructions are accepted only in RUN; IN/OUT may stall in WAIT_IN/WAIT_OUT until the port handshake completes.
module exec_unit #(
   parameter int DW = 4,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [3:0]    opcode,
   input  logic [DW-1:0] imd,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] a_q,
   output logic [DW-1:0] b_q,
   output logic          carry
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] WAIT_IN  = 2'd1;
   localparam logic [1:0] WAIT_OUT = 2'd2;

   localparam logic [3:0] OP_ADAI = 4'b0000;
   localparam logic [3:0] OP_MVAB = 4'b0001;
   localparam logic [3:0] OP_INA  = 4'b0010;
   localparam logic [3:0] OP_MVAI = 4'b0011;
   localparam logic [3:0] OP_MVBA = 4'b0100;
   localparam logic [3:0] OP_ADBI = 4'b0101;
   localparam logic [3:0] OP_INB  = 4'b0110;
   localparam logic [3:0] OP_MVBI = 4'b0111;
   localparam logic [3:0] OP_SBAI = 4'b1000;
   localparam logic [3:0] OP_OUTB = 4'b1001;
   localparam logic [3:0] OP_SBBI = 4'b1010;
   localparam logic [3:0] OP_OUTI = 4'b1011;
   localparam logic [3:0] OP_JNCI = 4'b1110;
   localparam logic [3:0] OP_JMPI = 4'b1111;

   logic [1:0]    state;
   logic          wait_b;
   logic          is_in;
   logic [DW:0]   add_a, add_b, sub_a, sub_b;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] jmp_tgt;

   // Extra top bit carries the carry-out on add and the borrow on subtract.
   assign add_a   = {1'b0, a_q} + {1'b0, imd};
   assign add_b   = {1'b0, b_q} + {1'b0, imd};
   assign sub_a   = {1'b0, a_q} - {1'b0, imd};
   assign sub_b   = {1'b0, b_q} - {1'b0, imd};
   assign pc_inc  = pc + AW'(1);
   assign jmp_tgt = AW'(imd);
   assign is_in   = (opcode == OP_INA) || (opcode == OP_INB);

   assign instr_ready = !rst && (state == RUN);

   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (state == RUN)
            in_ready = instr_valid && is_in && in_valid;
         else if (state == WAIT_IN)
            in_ready = in_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         wait_b    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         carry     <= 1'b0;
         pc        <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (instr_valid) begin
                  carry <= 1'b0;
                  pc    <= pc_inc;
                  case (opcode)
                     OP_ADAI: begin a_q <= add_a[DW-1:0]; carry <= add_a[DW]; end
                     OP_ADBI: begin b_q <= add_b[DW-1:0]; carry <= add_b[DW]; end
                     OP_SBAI: begin a_q <= sub_a[DW-1:0]; carry <= sub_a[DW]; end
                     OP_SBBI: begin b_q <= sub_b[DW-1:0]; carry <= sub_b[DW]; end
                     OP_MVAB: a_q <= b_q;
                     OP_MVAI: a_q <= imd;
                     OP_MVBA: b_q <= a_q;
                     OP_MVBI: b_q <= imd;
                     OP_INA, OP_INB: begin
                        if (in_valid) begin
                           if (opcode == OP_INB) b_q <= in_data;
                           else                  a_q <= in_data;
                        end else begin
                           // Not complete yet: pc and carry stay until the data arrives.
                           carry  <= carry;
                           pc     <= pc;
                           wait_b <= (opcode == OP_INB);
                           state  <= WAIT_IN;
                        end
                     end
                     OP_OUTB, OP_OUTI: begin
                        out_data  <= (opcode == OP_OUTB) ? b_q : imd;
                        out_valid <= 1'b1;
                        state     <= WAIT_OUT;
                     end
                     OP_JNCI: if (!carry) pc <= jmp_tgt;
                     OP_JMPI: pc <= jmp_tgt;
                     default: ;
                  endcase
               end
            end
            WAIT_IN: begin
               if (in_valid) begin
                  if (wait_b) b_q <= in_data;
                  else        a_q <= in_data;
                  carry <= 1'b0;
                  pc    <= pc_inc;
                  state <= RUN;
               end
            end
            WAIT_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed-vector bench for exec_unit at DW=4, AW=4
module tb_exec_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] opcode;
   logic [3:0] imd;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] pc;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       carry;

   int checks = 0;
   int failures = 0;

   exec_unit #(.DW(4), .AW(4)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .imd(imd),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .pc(pc), .a_q(a_q), .b_q(b_q), .carry(carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one instruction for exactly one edge; returns #1 after that edge.
   task automatic exec(input logic [3:0] op, input logic [3:0] val);
      opcode      = op;
      imd         = val;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      instr_valid = 1'b1;
      opcode = 4'b0010;
      imd = 4'd0;
      in_data = 4'd0;
      in_valid = 1'b1;
      out_ready = 1'b0;
      #2;
      check("rst_instr_ready", instr_ready, 0);
      check("rst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("rst_a", a_q, 0);
      check("rst_b", b_q, 0);
      check("rst_pc", pc, 0);
      check("rst_carry", carry, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      instr_valid = 1'b0;
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("run_instr_ready", instr_ready, 1);

      exec(4'b0011, 4'd9);                       // MVAI 9
      check("mvai_a", a_q, 9);
      check("mvai_pc", pc, 1);
      exec(4'b0000, 4'd8);                       // ADAI 8
      check("adai_a", a_q, 1);
      check("adai_carry", carry, 1);
      check("adai_pc", pc, 2);
      exec(4'b1110, 4'd5);                       // JNCI 5, carry set
      check("jnci_nt_pc", pc, 3);
      check("jnci_nt_carry", carry, 0);

      exec(4'b0111, 4'd3);                       // MVBI 3
      check("mvbi_b", b_q, 3);
      exec(4'b1010, 4'd5);                       // SBBI 5
      check("sbbi_b", b_q, 14);
      check("sbbi_borrow", carry, 1);
      check("sbbi_pc", pc, 5);
      exec(4'b0001, 4'd0);                       // MVAB
      check("mvab_a", a_q, 14);
      check("mvab_carry", carry, 0);
      exec(4'b1110, 4'd12);                      // JNCI 12, carry clear
      check("jnci_t_pc", pc, 12);
      exec(4'b0101, 4'd2);                       // ADBI 2
      check("adbi_b", b_q, 0);
      check("adbi_carry", carry, 1);
      check("adbi_pc", pc, 13);
      exec(4'b1100, 4'd0);                       // NOP
      check("nop_carry", carry, 0);
      check("nop_pc", pc, 14);

      // INA with input stalled for 3 cycles
      exec(4'b0010, 4'd0);
      check("ina_wait_pc", pc, 14);
      for (int i = 0; i < 3; i++) begin
         check("ina_wait_instr_ready", instr_ready, 0);
         check("ina_wait_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      check("ina_wait_a", a_q, 14);
      in_data = 4'd6;
      in_valid = 1'b1;
      #1;
      check("ina_in_ready_pulse", in_ready, 1);
      @(posedge clk); #1;
      check("ina_in_ready_drop", in_ready, 0);
      in_valid = 1'b0;
      check("ina_a", a_q, 6);
      check("ina_pc", pc, 15);
      check("ina_instr_ready", instr_ready, 1);

      exec(4'b1101, 4'd0);                       // NOP wraps pc
      check("nop_wrap_pc", pc, 0);
      exec(4'b1111, 4'd7);                       // JMPI 7
      check("jmpi_pc", pc, 7);

      // INB with data already valid completes on accept
      in_data = 4'd13;
      in_valid = 1'b1;
      opcode = 4'b0110;
      instr_valid = 1'b1;
      #1;
      check("inb_in_ready", in_ready, 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      in_valid = 1'b0;
      check("inb_b", b_q, 13);
      check("inb_pc", pc, 8);

      // OUTI 10 with sink stalled 4 cycles; a stray MVAI must be ignored
      exec(4'b1011, 4'd10);
      opcode = 4'b0011;
      imd = 4'd3;
      instr_valid = 1'b1;
      check("outi_pc", pc, 9);
      for (int i = 0; i < 4; i++) begin
         check("outi_hold_valid", out_valid, 1);
         check("outi_hold_data", out_data, 10);
         check("outi_instr_ready", instr_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      out_ready = 1'b0;
      check("outi_done_valid", out_valid, 0);
      check("outi_done_data", out_data, 10);
      check("outi_instr_ready", instr_ready, 1);
      check("outi_ignored_a", a_q, 6);
      check("outi_done_pc", pc, 9);

      // OUTB with immediate sink
      out_ready = 1'b1;
      exec(4'b1001, 4'd0);
      check("outb_data", out_data, 13);
      check("outb_valid", out_valid, 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("outb_done_valid", out_valid, 0);
      check("outb_pc", pc, 10);

      exec(4'b0011, 4'd2);                       // MVAI 2
      exec(4'b1000, 4'd5);                       // SBAI 5
      check("sbai_a", a_q, 13);
      check("sbai_borrow", carry, 1);
      exec(4'b0100, 4'd0);                       // MVBA
      check("mvba_b", b_q, 13);
      check("mvba_carry", carry, 0);

      // Reset mid WAIT_OUT, between edges
      exec(4'b1011, 4'd5);
      check("outi2_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("amid_out_valid", out_valid, 0);
      check("amid_out_data", out_data, 0);
      check("amid_pc", pc, 0);
      check("amid_a", a_q, 0);
      check("amid_b", b_q, 0);
      check("amid_carry", carry, 0);
      check("amid_instr_ready", instr_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst_instr_ready", instr_ready, 1);
      exec(4'b0111, 4'd4);                       // MVBI 4
      check("post_rst_b", b_q, 4);
      check("post_rst_pc", pc, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
